// File: rtl/exu_pkg.sv
// exu_pkg: shared definitions for the NPC execute stage.
//   - EXU_W          default operand/result width
//   - ALU_*          operation codes 0..10 (11..15 produce 0)
//   - exu_state_e    execute-stage state encoding
package exu_pkg;

  localparam int EXU_W = 64;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_GEU = 4'd7;
  localparam logic [3:0] ALU_LTU = 4'd8;
  localparam logic [3:0] ALU_EQ  = 4'd9;
  localparam logic [3:0] ALU_NE  = 4'd10;

  typedef enum logic [1:0] {
    EXU_IDLE = 2'd0,
    EXU_BUSY = 2'd1,
    EXU_FULL = 2'd2
  } exu_state_e;

endpackage

// File: rtl/exu_div.sv
// exu_div: restoring radix-2 unsigned divider, one quotient bit per clock.
// Only instantiated when EXU_DIV_ITER_EN is defined.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       load a/b and begin N iterations (b must be non-zero)
//   abort       cancel the running division; clears busy and suppresses done
//   a, b        dividend, divisor
//   busy        iteration in progress
//   done        single-cycle pulse in the cycle whose edge retires the last
//               iteration; quot carries the final quotient in that cycle
//   quot        quotient after the iteration performed at the next edge
module exu_div
  import exu_pkg::*;
#(
  parameter int N = EXU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quot
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  quo_q, div_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [N:0]    rem_sh, rem_sub;
  logic          take;
  logic [N-1:0]  quo_d, rem_d;

  // Shift the next dividend bit into the partial remainder and try to
  // subtract; the remainder stays below the divisor so N+1 bits suffice.
  always_comb begin
    rem_sh  = {rem_q, quo_q[N-1]};
    rem_sub = rem_sh - {1'b0, div_q};
    take    = (rem_sh >= {1'b0, div_q});
    quo_d   = {quo_q[N-2:0], take};
    rem_d   = take ? rem_sub[N-1:0] : rem_sh[N-1:0];
  end

  // done is combinational so the consumer captures quot on the same edge
  // that performs the final iteration: N edges after start in total.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1)) && !abort && !rst;
  assign quot = quo_d;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(N);
      quo_q  <= a;
      rem_q  <= '0;
      div_q  <= b;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exu_stage.sv
// exu_stage: execute stage between decode and writeback.
// Accepts one ALU operation per in_valid/in_ready handshake and holds the
// result in a single output register until writeback takes it.
// Build option: EXU_DIV_ITER_EN -- when defined, op 3 with B!=0 runs on the
// iterative divider (N cycles, stage BUSY); otherwise division is a
// single-cycle combinational A/B. Division by zero always yields all ones.
// Ports:
//   clk, rst              clock, synchronous active-high reset (beats flush)
//   flush                 discard in-flight/held op; in_valid ignored
//   in_valid/in_ready     decode handshake; in_a, in_b, in_op, in_rd
//   out_valid/out_ready   writeback handshake; out_res, out_rd
module exu_stage
  import exu_pkg::*;
#(
  parameter int N = EXU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [3:0]   in_op,
  input  logic [4:0]   in_rd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_res,
  output logic [4:0]   out_rd
);

  exu_state_e   state_q;
  logic [N-1:0] res_q;
  logic [4:0]   rd_q;

  logic         acc;
  logic         iter_div;
  logic [N-1:0] alu_res;
  logic         div_done;
  logic [N-1:0] div_quot;

  // A held result may be replaced in the same cycle writeback drains it.
  assign in_ready  = !flush && ((state_q == EXU_IDLE) ||
                                ((state_q == EXU_FULL) && out_ready));
  assign acc       = in_valid && in_ready;
  assign out_valid = (state_q == EXU_FULL);
  assign out_res   = res_q;
  assign out_rd    = rd_q;

  always_comb begin
    alu_res = '0;
    case (in_op)
      ALU_ADD: alu_res = in_a + in_b;
      ALU_SUB: alu_res = in_a - in_b;
      ALU_MUL: alu_res = in_a * in_b;
`ifdef EXU_DIV_ITER_EN
      // Non-zero divisors go to the iterative divider; this path only
      // ever supplies the divide-by-zero result.
      ALU_DIV: alu_res = (in_b == '0) ? '1 : '0;
`else
      ALU_DIV: alu_res = (in_b == '0) ? '1 : in_a / in_b;
`endif
      ALU_AND: alu_res = in_a & in_b;
      ALU_OR:  alu_res = in_a | in_b;
      ALU_XOR: alu_res = in_a ^ in_b;
      ALU_GEU: alu_res = {{(N-1){1'b0}}, (in_a >= in_b)};
      ALU_LTU: alu_res = {{(N-1){1'b0}}, (in_a <  in_b)};
      ALU_EQ:  alu_res = {{(N-1){1'b0}}, (in_a == in_b)};
      ALU_NE:  alu_res = {{(N-1){1'b0}}, (in_a != in_b)};
      default: alu_res = '0;
    endcase
  end

`ifdef EXU_DIV_ITER_EN
  logic div_busy_unused;

  assign iter_div = (in_op == ALU_DIV) && (in_b != '0);

  exu_div #(.N(N)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (acc && iter_div),
    .abort (flush),
    .a     (in_a),
    .b     (in_b),
    .busy  (div_busy_unused),
    .done  (div_done),
    .quot  (div_quot)
  );
`else
  assign iter_div = 1'b0;
  assign div_done = 1'b0;
  assign div_quot = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXU_IDLE;
      res_q   <= '0;
      rd_q    <= '0;
    end else if (flush) begin
      state_q <= EXU_IDLE;
    end else begin
      case (state_q)
        EXU_BUSY: begin
          if (div_done) begin
            state_q <= EXU_FULL;
            res_q   <= div_quot;
          end
        end
        EXU_IDLE, EXU_FULL: begin
          if (acc) begin
            rd_q <= in_rd;
            if (iter_div) begin
              state_q <= EXU_BUSY;
            end else begin
              state_q <= EXU_FULL;
              res_q   <= alu_res;
            end
          end else if (state_q == EXU_FULL && out_ready) begin
            state_q <= EXU_IDLE;
          end
        end
        default: state_q <= EXU_IDLE;
      endcase
    end
  end

endmodule
